// File: rtl/vec_store_serializer_if.sv
// Bundles the store-request, register-file read and memory-write signals of vec_store_serializer.
// With VEC_STORE_MASK_EN defined, this interface also carries the per-lane request mask.
interface vec_store_serializer_if #(
  parameter int unsigned RW         = 3,
  parameter int unsigned ELEM_WIDTH = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                                reqValid;
  logic                                reqReady;
  logic [RW-1:0]                       reqReg;
  logic [ADDR_WIDTH-1:0]               reqAddr;
`ifdef VEC_STORE_MASK_EN
  logic [LANES-1:0]                    reqMask;
`endif
  logic [RW-1:0]                       rSel;
  logic [LANES-1:0][ELEM_WIDTH-1:0]    regData;
  logic                                memWrEn;
  logic [ADDR_WIDTH-1:0]               memAddr;
  logic [ELEM_WIDTH-1:0]               memData;
  logic                                memReady;
  logic                                busy;
  logic                                done;

  modport slave (
    input  reqValid, reqReg, reqAddr, regData, memReady,
`ifdef VEC_STORE_MASK_EN
    input  reqMask,
`endif
    output reqReady, rSel, memWrEn, memAddr, memData, busy, done
  );

  modport master (
    output reqValid, reqReg, reqAddr, regData, memReady,
`ifdef VEC_STORE_MASK_EN
    output reqMask,
`endif
    input  reqReady, rSel, memWrEn, memAddr, memData, busy, done
  );
endinterface

// File: rtl/vec_store_serializer.sv
// Vector store unit: reads one vector register, snapshots it, then writes one byte per lane
// to memory. Optional per-lane write mask enabled by defining VEC_STORE_MASK_EN.
module vec_store_serializer #(
  parameter int unsigned REG_COUNT  = 8,
  parameter int unsigned ELEM_WIDTH = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  vec_store_serializer_if.slave  bus
);
  localparam int unsigned RW = $clog2(REG_COUNT);
  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  state_t                           state, state_nx;
  logic [RW-1:0]                    rsel_q;
  logic [ADDR_WIDTH-1:0]            base_q;
  logic [LW-1:0]                    lane_q;
  logic [LANES-1:0][ELEM_WIDTH-1:0] snap_q;
  logic                             lane_en;
  logic                             advance;
  logic                             last_lane;

`ifdef VEC_STORE_MASK_EN
  logic [LANES-1:0]                 mask_q;
  assign lane_en = mask_q[lane_q];
`else
  assign lane_en = 1'b1;
`endif

  // A masked-off lane spends exactly one cycle and never waits on memReady.
  assign advance   = (state == SEND) && (lane_en ? bus.memReady : 1'b1);
  assign last_lane = (lane_q == LW'(LANES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.reqValid)         state_nx = READ;
      READ:                           state_nx = SEND;
      SEND: if (advance && last_lane) state_nx = DONE;
      DONE:                           state_nx = IDLE;
      default:                        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsel_q <= '0;
      base_q <= '0;
      lane_q <= '0;
      snap_q <= '0;
`ifdef VEC_STORE_MASK_EN
      mask_q <= '0;
`endif
    end else begin
      if (state == IDLE && bus.reqValid) begin
        rsel_q <= bus.reqReg;
        base_q <= bus.reqAddr;
        lane_q <= '0;
`ifdef VEC_STORE_MASK_EN
        mask_q <= bus.reqMask;
`endif
      end
      if (state == READ) snap_q <= bus.regData;
      if (advance) lane_q <= last_lane ? '0 : lane_q + 1'b1;
    end
  end

  // Outputs decode from state, so an asynchronous reset drops memWrEn immediately.
  always_comb begin
    bus.reqReady = (state == IDLE);
    bus.busy     = (state != IDLE);
    bus.done     = (state == DONE);
    bus.rSel     = rsel_q;
    bus.memWrEn  = (state == SEND) && lane_en;
    bus.memAddr  = '0;
    bus.memData  = '0;
    if (state == SEND) begin
      bus.memAddr = base_q + ADDR_WIDTH'(lane_q);
      bus.memData = snap_q[LW'(LANES - 1) - lane_q];
    end
  end
endmodule

// File: tb/tb_vec_store_serializer.sv
// Directed bench for vec_store_serializer: scoreboard of expected (addr, byte) writes,
// done-latency and handshake checks, stall, snapshot and mid-operation reset cases.
module tb_vec_store_serializer;
  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] regs [8];
  wr_t         expq [$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  int          done_cyc = 0;
  int          done_count = 0;
  int          last_wr_cyc = 0;
  int          stall_left = 0;
  logic [15:0] stall_addr = '0;
  logic [3:0]  mask_v = 4'hF;
  int          lat;

  vec_store_serializer_if #(.RW(3), .ELEM_WIDTH(8), .LANES(4), .ADDR_WIDTH(16)) bus ();

  vec_store_serializer #(
    .REG_COUNT(8), .ELEM_WIDTH(8), .LANES(4), .ADDR_WIDTH(16)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  assign bus.regData = regs[bus.rSel];
`ifdef VEC_STORE_MASK_EN
  assign bus.reqMask = mask_v;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model: ready unless a stall is armed for the address currently presented.
  initial bus.memReady = 1'b1;
  always @(posedge clk) begin
    #1;
    if (bus.memWrEn && bus.memAddr == stall_addr && stall_left > 0) begin
      bus.memReady = 1'b0;
      stall_left--;
    end else begin
      bus.memReady = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (bus.memWrEn && bus.memReady) begin
      if (expq.size() == 0) begin
        check("unexpected_write", {16'h0, bus.memAddr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = expq.pop_front();
        check("wr_addr", {16'h0, bus.memAddr}, {16'h0, e.a});
        check("wr_data", {24'h0, bus.memData}, {24'h0, e.d});
      end
      last_wr_cyc = cyc;
    end else if (bus.memWrEn && !bus.memReady && expq.size() > 0) begin
      check("stall_addr_hold", {16'h0, bus.memAddr}, {16'h0, expq[0].a});
      check("stall_data_hold", {24'h0, bus.memData}, {24'h0, expq[0].d});
    end
    if (bus.done) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  task automatic push_vec(input logic [15:0] base, input logic [31:0] val, input logic [3:0] m);
    for (int unsigned i = 0; i < 4; i++) begin
      wr_t e;
      logic [31:0] sh;
      sh  = val >> (8 * (3 - i));
      e.a = base + 16'(i);
      e.d = sh[7:0];
      if (m[i]) expq.push_back(e);
    end
  endtask

  // Called at posedge+1 with the unit idle; returns after the accepting edge.
  task automatic issue(input logic [2:0] r, input logic [15:0] addr, input bit hold);
    bus.reqValid = 1'b1;
    bus.reqReg   = r;
    bus.reqAddr  = addr;
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    if (!hold) bus.reqValid = 1'b0;
  endtask

  task automatic wait_done(output int l);
    int start;
    start = done_count;
    l = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (done_count != start) begin
        l = done_cyc - accept_cyc;
        break;
      end
    end
    if (l < 0) check("done_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = 32'h0;
    regs[1] = 32'hDEADBEEF;
    regs[7] = 32'h1A2B3C4D;
    bus.reqValid = 1'b0;
    bus.reqReg   = '0;
    bus.reqAddr  = '0;

    repeat (2) @(negedge clk);
    check("rst_reqReady", {31'h0, bus.reqReady}, 32'h1);
    check("rst_rSel",     {29'h0, bus.rSel},     32'h0);
    check("rst_memWrEn",  {31'h0, bus.memWrEn},  32'h0);
    check("rst_memAddr",  {16'h0, bus.memAddr},  32'h0);
    check("rst_memData",  {24'h0, bus.memData},  32'h0);
    check("rst_busy",     {31'h0, bus.busy},     32'h0);
    check("rst_done",     {31'h0, bus.done},     32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1) basic store, back-to-back writes, done one cycle after last write
    push_vec(16'h0010, 32'hDEADBEEF, 4'hF);
    issue(3'd1, 16'h0010, 1'b0);
    @(negedge clk);
    check("t1_read_rSel", {29'h0, bus.rSel}, 32'h1);
    check("t1_read_busy", {31'h0, bus.busy}, 32'h1);
    check("t1_read_reqReady", {31'h0, bus.reqReady}, 32'h0);
    wait_done(lat);
    check("t1_latency", lat, 32'd5);
    check("t1_done_after_last", done_cyc - last_wr_cyc, 32'd1);
    check("t1_q_empty", expq.size(), 32'd0);

    // 2) address wraps modulo 2^16
    push_vec(16'hFFFE, 32'h1A2B3C4D, 4'hF);
    issue(3'd7, 16'hFFFE, 1'b0);
    wait_done(lat);
    check("t2_latency", lat, 32'd5);
    check("t2_q_empty", expq.size(), 32'd0);

    // 3) three-cycle stall on lane 1 stretches latency by exactly 3
    stall_addr = 16'h0011;
    stall_left = 3;
    push_vec(16'h0010, 32'hDEADBEEF, 4'hF);
    issue(3'd1, 16'h0010, 1'b0);
    wait_done(lat);
    check("t3_latency", lat, 32'd8);
    check("t3_q_empty", expq.size(), 32'd0);

    // 4) request held while busy is accepted in the cycle after done
    push_vec(16'h0020, 32'hDEADBEEF, 4'hF);
    push_vec(16'h0030, 32'h1A2B3C4D, 4'hF);
    issue(3'd1, 16'h0020, 1'b1);
    bus.reqReg  = 3'd7;
    bus.reqAddr = 16'h0030;
    @(negedge clk);
    check("t4_busy_reqReady", {31'h0, bus.reqReady}, 32'h0);
    check("t4_no_relatch_rSel", {29'h0, bus.rSel}, 32'h1);
    wait_done(lat);
    check("t4_first_latency", lat, 32'd5);
    check("t4_idle_reqReady", {31'h0, bus.reqReady}, 32'h1);
    @(posedge clk);
    #1;
    bus.reqValid = 1'b0;
    accept_cyc = cyc;
    check("t4_second_rSel", {29'h0, bus.rSel}, 32'h7);
    check("t4_second_busy", {31'h0, bus.busy}, 32'h1);
    wait_done(lat);
    check("t4_second_latency", lat, 32'd5);
    check("t4_q_empty", expq.size(), 32'd0);

    // 5) register overwritten after READ does not change stored bytes
    push_vec(16'h0100, 32'hDEADBEEF, 4'hF);
    issue(3'd1, 16'h0100, 1'b0);
    @(posedge clk);
    #1 regs[1] = 32'h0;
    wait_done(lat);
    check("t5_q_empty", expq.size(), 32'd0);
    regs[1] = 32'hDEADBEEF;

    // 6) reset during lane 2: only lanes 0,1 written, no done pulse
    push_vec(16'h0040, 32'hDEADBEEF, 4'h3);
    lat = done_count;
    issue(3'd1, 16'h0040, 1'b0);
    for (int k = 0; k < 20; k++) begin
      if (bus.memWrEn && bus.memAddr == 16'h0042) break;
      @(posedge clk);
      #1;
    end
    check("t6_reached_lane2", {16'h0, bus.memAddr}, 32'h0042);
    rst_n = 1'b0;
    #1;
    check("t6_memWrEn_drop", {31'h0, bus.memWrEn}, 32'h0);
    check("t6_busy_drop", {31'h0, bus.busy}, 32'h0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6_reqReady", {31'h0, bus.reqReady}, 32'h1);
    check("t6_no_done", done_count, lat);
    check("t6_q_empty", expq.size(), 32'd0);
    @(posedge clk);
    #1;

`ifdef VEC_STORE_MASK_EN
    // masked store: lanes 0 and 2 written, masked lanes take one cycle each
    mask_v = 4'b0101;
    push_vec(16'h0200, 32'hDEADBEEF, 4'b0101);
    issue(3'd1, 16'h0200, 1'b0);
    wait_done(lat);
    check("m_latency", lat, 32'd5);
    check("m_q_empty", expq.size(), 32'd0);
    mask_v = 4'b0000;
    issue(3'd1, 16'h0300, 1'b0);
    wait_done(lat);
    check("m_zero_latency", lat, 32'd5);
    mask_v = 4'hF;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
